// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the handshaked data memory (data_memory_hs):
//   - RV32I load/store funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - FSM state encoding (IDLE, WAIT, RESP)
//   - byte_mask(): byte-lane write enables for sb/sh/sw
// Optional feature macro used by the importing files: DMEM_MISALIGN_FAULT_EN.
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Byte-lane enables for a store. Halfword and word stores use only the
  // upper offset bits, so a misaligned access is aligned down here.
  function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] mask;
    case (funct3[1:0])
      2'b00:   mask = 4'b0001 << off;
      2'b01:   mask = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// -----------------------------------------------------------------------------
// dmem_load_align
// Combinational load formatter: selects the byte/half lane addressed by off and
// sign- or zero-extends it according to funct3. Halfword accesses use only
// off[1] and word accesses ignore off entirely (aligned down).
// Ports:
//   word   in  32  raw memory word
//   off    in  2   low byte-offset bits of the access
//   funct3 in  3   RV32I load encoding
//   value  out 32  extended load result (0 for unsupported funct3)
// -----------------------------------------------------------------------------
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection for byte and halfword loads.
  always_comb begin
    case (off)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (off[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
  end

  // Extension according to access size and signedness.
  always_comb begin
    case (funct3)
      F3_B:    value = {{24{byte_s[7]}}, byte_s};
      F3_BU:   value = {24'h000000, byte_s};
      F3_H:    value = {{16{half_s[15]}}, half_s};
      F3_HU:   value = {16'h0000, half_s};
      F3_W:    value = word;
      default: value = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_memory_hs.sv
// -----------------------------------------------------------------------------
// data_memory_hs
// Handshaked MEM-stage data memory with byte/half/word loads and stores,
// configurable read latency and fault reporting. One request outstanding.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready  request handshake; req_ready is high only in IDLE
//   req_we, funct3       store/load select and RV32I access size/sign
//   req_addr, req_wdata  byte address and LSB-aligned store data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata, rsp_fault load result (0 for stores/faults) and fault flag
// Configuration macro: DMEM_MISALIGN_FAULT_EN -- when defined, misaligned
// halfword/word accesses fault; otherwise they are silently aligned down.
// -----------------------------------------------------------------------------
module data_memory_hs
  import dmem_pkg::*;
#(
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter int unsigned                DATA_WIDTH    = 32,
  parameter int unsigned                MEM_WORDS     = 1024,
  parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = {ADDRESS_WIDTH{1'b0}},
  parameter int unsigned                READ_LATENCY  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_fault
);

  localparam int unsigned            IDX_W  = $clog2(MEM_WORDS);
  localparam logic [ADDRESS_WIDTH:0] SPAN   = (ADDRESS_WIDTH + 1)'(MEM_WORDS * 4);
  localparam logic [2:0]             LAT_M1 = 3'(READ_LATENCY - 1);

  logic [DATA_WIDTH-1:0]    mem_r [MEM_WORDS];
  dmem_state_t              state_r, state_n;
  logic [2:0]               cnt_r, cnt_n;
  logic [DATA_WIDTH-1:0]    rdata_r;
  logic                     fault_r;

  logic                     req_ready_s, rsp_valid_s, accept_s;
  logic [ADDRESS_WIDTH-1:0] off_s;
  logic [IDX_W-1:0]         idx_s;
  logic                     in_range_s, supported_s, misalign_s, fault_s, wr_en_s;
  logic [3:0]               wmask_s;
  logic [DATA_WIDTH-1:0]    wlanes_s, rd_word_s, load_val_s;

  // Address decode and range check; no modulo wrap beyond the array.
  always_comb begin
    off_s      = req_addr - BASE_ADDR;
    idx_s      = off_s[2 +: IDX_W];
    in_range_s = (req_addr >= BASE_ADDR) && ({1'b0, off_s} < SPAN);
    rd_word_s  = mem_r[idx_s];
  end

  // Supported funct3 set differs for loads and stores.
  always_comb begin
    if (req_we) begin
      case (funct3)
        F3_B, F3_H, F3_W: supported_s = 1'b1;
        default:          supported_s = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: supported_s = 1'b1;
        default:                        supported_s = 1'b0;
      endcase
    end
  end

  // Misalignment detection (only active with DMEM_MISALIGN_FAULT_EN).
  always_comb begin
`ifdef DMEM_MISALIGN_FAULT_EN
    case (funct3)
      F3_H, F3_HU: misalign_s = off_s[0];
      F3_W:        misalign_s = |off_s[1:0];
      default:     misalign_s = 1'b0;
    endcase
`else
    misalign_s = 1'b0;
`endif
  end

  // Fault combination, handshake acceptance and store lane data.
  always_comb begin
    fault_s  = ~in_range_s | ~supported_s | misalign_s;
    accept_s = req_valid & req_ready_s & ~rst;
    wr_en_s  = accept_s & req_we & ~fault_s;
    wmask_s  = byte_mask(funct3, off_s[1:0]);
    case (funct3[1:0])
      2'b00:   wlanes_s = {4{req_wdata[7:0]}};
      2'b01:   wlanes_s = {2{req_wdata[15:0]}};
      default: wlanes_s = req_wdata;
    endcase
  end

  dmem_load_align u_load_align (
    .word   (rd_word_s),
    .off    (off_s[1:0]),
    .funct3 (funct3),
    .value  (load_val_s)
  );

  // RAM byte-lane writes at the acceptance edge; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_s[b]) begin
          mem_r[idx_s][8*b +: 8] <= wlanes_s[8*b +: 8];
        end
      end
    end
  end

  // Response payload captured at acceptance and held until the next request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= {DATA_WIDTH{1'b0}};
      fault_r <= 1'b0;
    end else if (accept_s) begin
      fault_r <= fault_s;
      rdata_r <= (fault_s | req_we) ? {DATA_WIDTH{1'b0}} : load_val_s;
    end
  end

  // FSM state and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Next-state logic; WAIT moves to RESP on the edge where the counter hits 0.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_n = (READ_LATENCY == 1) ? RESP : WAIT;
          cnt_n   = LAT_M1;
        end else begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        cnt_n = cnt_r - 3'd1;
        if (cnt_r == 3'd1) begin
          state_n = RESP;
        end else begin
          state_n = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_n = IDLE;
        end else begin
          state_n = RESP;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 3'd0;
      end
    endcase
  end

  // Output decode from the state register only (no path from rsp_ready).
  always_comb begin
    case (state_r)
      IDLE:    begin req_ready_s = 1'b1; rsp_valid_s = 1'b0; end
      WAIT:    begin req_ready_s = 1'b0; rsp_valid_s = 1'b0; end
      RESP:    begin req_ready_s = 1'b0; rsp_valid_s = 1'b1; end
      default: begin req_ready_s = 1'b0; rsp_valid_s = 1'b0; end
    endcase
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_s;
  assign rsp_rdata = rdata_r;
  assign rsp_fault = fault_r;

endmodule

// File: tb/tb_data_memory_hs.sv
// -----------------------------------------------------------------------------
// tb_data_memory_hs
// Directed and randomized checks of data_memory_hs against a byte-array model
// (BASE_ADDR = 0x1000, MEM_WORDS = 16, READ_LATENCY = 2).
// -----------------------------------------------------------------------------
module tb_data_memory_hs;
  import dmem_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_fault;
  logic [2:0]  funct3;
  logic [31:0] req_addr, req_wdata, rsp_rdata;

  int errors = 0;
  int checks = 0;
  logic [7:0] mb [64];

  data_memory_hs #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .MEM_WORDS     (16),
    .BASE_ADDR     (32'h0000_1000),
    .READ_LATENCY  (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .funct3    (funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_fault (rsp_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, size from funct3, align-down or fault.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic fault, output logic [31:0] rd);
    int unsigned size, o, base;
    logic [31:0] v, mask;
    bit ok;
    fault = 1'b0;
    rd    = 32'h0;
    if (we) ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!ok || addr < 32'h1000 || addr - 32'h1000 >= 32'd64) begin
      fault = 1'b1;
      return;
    end
    size = 1 << f3[1:0];
    o    = addr - 32'h1000;
`ifdef DMEM_MISALIGN_FAULT_EN
    if (o % size != 0) begin
      fault = 1'b1;
      return;
    end
`endif
    base = o - (o % size);
    if (we) begin
      for (int unsigned i = 0; i < size; i++) mb[base + i] = 8'((wd >> (8 * i)) & 32'hFF);
      return;
    end
    v = 32'h0;
    for (int unsigned i = 0; i < size; i++) v = v | (32'(mb[base + i]) << (8 * i));
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    if (!f3[2] && size < 4 && ((v >> (8 * size - 1)) & 32'd1) == 32'd1) v = v | ~mask;
    rd = v;
  endfunction

  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, input bit rst_in_wait);
    logic        ef;
    logic [31:0] er;
    int          n;
    model(we, f3, addr, wd, ef, er);
    @(negedge clk);
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    funct3    = f3;
    req_addr  = addr;
    req_wdata = wd;
    rsp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    if (rst_in_wait) begin
      chk({tag, "_in_wait"}, 32'(rsp_valid), 32'd0);
      rst = 1'b1;
      #1;
      chk({tag, "_rst_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rst_ready"}, 32'(req_ready), 32'd1);
      @(negedge clk);
      rst       = 1'b0;
      rsp_ready = 1'b1;
      return;
    end
    n = 1;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(LAT));
    chk({tag, "_rdata"}, rsp_rdata, er);
    chk({tag, "_fault"}, 32'(rsp_fault), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, rsp_rdata, er);
      chk({tag, "_hold_fault"}, 32'(rsp_fault), 32'(ef));
      chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    funct3    = 3'b000;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_fault", 32'(rsp_fault), 32'd0);
    rst = 1'b0;

    for (int w = 0; w < 16; w++) access("init", 1'b1, F3_W, 32'h1000 + 32'(4 * w), $urandom, 0, 1'b0);

    access("t1_sw", 1'b1, F3_W, 32'h1004, 32'hDEAD_BEEF, 0, 1'b0);
    access("t1_lw", 1'b0, F3_W, 32'h1004, 32'h0, 0, 1'b0);

    access("t2_sb",  1'b1, F3_B,  32'h1003, 32'h1234_56A5, 0, 1'b0);
    access("t2_lb",  1'b0, F3_B,  32'h1003, 32'h0, 0, 1'b0);
    access("t2_lbu", 1'b0, F3_BU, 32'h1003, 32'h0, 0, 1'b0);
    access("t2_lw",  1'b0, F3_W,  32'h1000, 32'h0, 0, 1'b0);

    access("t3_sh",  1'b1, F3_H,  32'h1002, 32'hCAFE_8001, 0, 1'b0);
    access("t3_lh",  1'b0, F3_H,  32'h1002, 32'h0, 0, 1'b0);
    access("t3_lhu", 1'b0, F3_HU, 32'h1002, 32'h0, 0, 1'b0);
    access("t3_lw",  1'b0, F3_W,  32'h1000, 32'h0, 0, 1'b0);

    access("t4_lw_oor", 1'b0, F3_W, 32'h1040, 32'h0, 0, 1'b0);
    access("t4_sw_low", 1'b1, F3_W, 32'h0FFC, 32'h5555_AAAA, 0, 1'b0);
    access("t4_sb_bad", 1'b1, F3_BU, 32'h1008, 32'h0000_0077, 0, 1'b0);
    access("t4_ld_bad", 1'b0, 3'b011, 32'h1008, 32'h0, 0, 1'b0);

    access("t5_sw_mis", 1'b1, F3_W, 32'h1006, 32'h1234_5678, 0, 1'b0);
    access("t5_lw",     1'b0, F3_W, 32'h1004, 32'h0, 0, 1'b0);
    access("t5_lh_mis", 1'b0, F3_H, 32'h1005, 32'h0, 0, 1'b0);

    access("t6_hold",   1'b0, F3_W, 32'h1008, 32'h0, 5, 1'b0);
    access("t6_rst_sw", 1'b1, F3_W, 32'h100C, 32'h0BAD_F00D, 0, 1'b1);
    access("t6_after",  1'b0, F3_W, 32'h100C, 32'h0, 0, 1'b0);

    for (int k = 0; k < 60; k++) begin
      access("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'h0FF8 + 32'($urandom_range(0, 32'h50)), $urandom, $urandom_range(0, 2), 1'b0);
    end

    for (int w = 0; w < 16; w++) access("sweep", 1'b0, F3_W, 32'h1000 + 32'(4 * w), 32'h0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
